// File: rtl/freepdk45_sram_1w1r_128x52_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// freepdk45_sram_ctrl_pkg
// Shared constants and types for the 128x52 1W1R SRAM controller slice.
//   DATA_WIDTH  : macro word width (52)
//   ADDR_WIDTH  : macro address width (7 -> 128 words)
//   NUM_WMASKS  : write-mask bits, each covering DATA_WIDTH/NUM_WMASKS data bits
//   ctrl_state_e: controller FSM state (INIT zero-fill sweep, RUN normal service)
//   wr_req_t    : one write request payload {addr, data, wmask}
// -----------------------------------------------------------------------------
package freepdk45_sram_ctrl_pkg;

    localparam int DATA_WIDTH = 52;
    localparam int ADDR_WIDTH = 7;
    localparam int NUM_WMASKS = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [NUM_WMASKS-1:0] wmask;
    } wr_req_t;

endpackage

// File: rtl/freepdk45_sram_1w1r_128x52_ctrl_if.sv
// -----------------------------------------------------------------------------
// freepdk45_sram_1w1r_128x52_ctrl_if
// Client-side bus of the SRAM controller.
//   wr0_*/wr1_* : two write requesters (valid/ready + addr/data/wmask payload)
//   rd_valid/rd_ready/rd_addr    : read request channel
//   rd_rvalid/rd_rready/rd_rdata : back-pressured read response channel
// Modports: master = datapath client, slave = controller.
// -----------------------------------------------------------------------------
interface freepdk45_sram_1w1r_128x52_ctrl_if;
    import freepdk45_sram_ctrl_pkg::*;

    logic                  wr0_valid;
    logic                  wr0_ready;
    logic [ADDR_WIDTH-1:0] wr0_addr;
    logic [DATA_WIDTH-1:0] wr0_data;
    logic [NUM_WMASKS-1:0] wr0_wmask;

    logic                  wr1_valid;
    logic                  wr1_ready;
    logic [ADDR_WIDTH-1:0] wr1_addr;
    logic [DATA_WIDTH-1:0] wr1_data;
    logic [NUM_WMASKS-1:0] wr1_wmask;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic                  rd_rvalid;
    logic                  rd_rready;
    logic [DATA_WIDTH-1:0] rd_rdata;

    modport master (
        output wr0_valid, wr0_addr, wr0_data, wr0_wmask,
        input  wr0_ready,
        output wr1_valid, wr1_addr, wr1_data, wr1_wmask,
        input  wr1_ready,
        output rd_valid, rd_addr,
        input  rd_ready,
        input  rd_rvalid, rd_rdata,
        output rd_rready
    );

    modport slave (
        input  wr0_valid, wr0_addr, wr0_data, wr0_wmask,
        output wr0_ready,
        input  wr1_valid, wr1_addr, wr1_data, wr1_wmask,
        output wr1_ready,
        input  rd_valid, rd_addr,
        output rd_ready,
        output rd_rvalid, rd_rdata,
        input  rd_rready
    );

endinterface

// File: rtl/freepdk45_sram_1w1r_128x52_ctrl_rsp_fifo.sv
// -----------------------------------------------------------------------------
// freepdk45_sram_rsp_fifo
// 2-entry synchronous FIFO holding read responses until the client takes them.
//   clk0, rst            : clock, synchronous active-high reset (flushes)
//   push, push_data      : enqueue (ignored when full and not popping)
//   pop, pop_data        : dequeue; pop_data is the head entry (show-ahead)
//   full, empty, count   : occupancy status
// -----------------------------------------------------------------------------
module freepdk45_sram_rsp_fifo
    import freepdk45_sram_ctrl_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk0,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk0) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            // NOTE: storage is normally left unreset; these two words are reset
            // only so the response data bus reads zero out of reset.
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/freepdk45_sram_1w1r_128x52_ctrl.sv
// -----------------------------------------------------------------------------
// freepdk45_sram_1w1r_128x52_ctrl
// Controller in front of the 128x52 1W1R SRAM macro (13-bit mask granules).
//   clk0, rst      : clock (also macro clk0/clk1), synchronous active-high reset
//   bus (slave)    : two write requesters, read request + response channels
//   init_done      : high once the zero-fill sweep is over (RUN)
//   sram_*0        : macro write port (csb active low, wmask, addr, din)
//   sram_*1        : macro read port (csb active low, addr), sram_dout1 data
// Write port is round-robin arbitrated; reads are credit-limited by a 2-entry
// response FIFO; a read colliding with a same-cycle write to the same address
// is held off one cycle so it returns the new data.
// -----------------------------------------------------------------------------
module freepdk45_sram_1w1r_128x52_ctrl
    import freepdk45_sram_ctrl_pkg::*;
#(
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                            clk0,
    input  logic                            rst,
    freepdk45_sram_1w1r_128x52_ctrl_if.slave bus,
    output logic                            init_done,
    output logic                            sram_csb0,
    output logic [NUM_WMASKS-1:0]           sram_wmask0,
    output logic [ADDR_WIDTH-1:0]           sram_addr0,
    output logic [DATA_WIDTH-1:0]           sram_din0,
    output logic                            sram_csb1,
    output logic [ADDR_WIDTH-1:0]           sram_addr1,
    input  logic [DATA_WIDTH-1:0]           sram_dout1
);

    ctrl_state_e           state;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic                  prio_wr1;     // 1: wr1 wins the next contested cycle
    logic                  rd_inflight;  // macro read issued last cycle

    logic    run;
    logic    init_active;
    logic    grant0;
    logic    grant1;
    logic    wr_grant;
    wr_req_t req0;
    wr_req_t req1;
    wr_req_t wsel;
    logic    collision;
    logic    rsp_pop;
    logic    rd_accept;
    logic    has_credit;
    logic [2:0] used;

    logic       fifo_full;
    logic       fifo_empty;
    logic [1:0] fifo_count;

    // Outputs are forced to their idle values while rst is held.
    assign run         = (state == RUN) && !rst;
    assign init_active = (state == INIT) && !rst;
    assign init_done   = run;

    assign req0 = '{addr: bus.wr0_addr, data: bus.wr0_data, wmask: bus.wr0_wmask};
    assign req1 = '{addr: bus.wr1_addr, data: bus.wr1_data, wmask: bus.wr1_wmask};

    assign grant0   = run && bus.wr0_valid && (!bus.wr1_valid || !prio_wr1);
    assign grant1   = run && bus.wr1_valid && (!bus.wr0_valid ||  prio_wr1);
    assign wr_grant = grant0 || grant1;
    assign wsel     = grant1 ? req1 : req0;

    assign bus.wr0_ready = grant0;
    assign bus.wr1_ready = grant1;

    // Credit: a slot is free if FIFO entries plus the read in flight, less
    // any entry leaving this cycle, leave room; counting the pop keeps full
    // throughput with rd_rready held high.
    assign rsp_pop    = bus.rd_rvalid && bus.rd_rready;
    assign used       = {1'b0, fifo_count} + {2'b00, rd_inflight} - {2'b00, rsp_pop};
    assign has_credit = (used < 3'd2) && !(fifo_full && !rsp_pop);

    assign collision   = wr_grant && (wsel.addr == bus.rd_addr);
    assign bus.rd_ready = run && has_credit && !collision;
    assign rd_accept   = bus.rd_valid && bus.rd_ready;

    assign sram_csb1  = !rd_accept;
    assign sram_addr1 = rd_accept ? bus.rd_addr : '0;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        sram_csb0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (init_active) begin
            sram_csb0   = 1'b0;
            sram_wmask0 = '1;
            sram_addr0  = init_addr;
        end else if (wr_grant) begin
            sram_csb0   = 1'b0;
            sram_wmask0 = wsel.wmask;
            sram_addr0  = wsel.addr;
            sram_din0   = wsel.data;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            state       <= INIT_ON_RESET ? INIT : RUN;
            init_addr   <= '0;
            prio_wr1    <= 1'b0;
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= rd_accept;
            if (grant0) begin
                prio_wr1 <= 1'b1;
            end else if (grant1) begin
                prio_wr1 <= 1'b0;
            end
            case (state)
                INIT: begin
                    init_addr <= init_addr + 1'b1;
                    if (&init_addr) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // The macro presents read data the cycle after the read is issued.
    freepdk45_sram_rsp_fifo #(.WIDTH(DATA_WIDTH)) u_rsp_fifo (
        .clk0      (clk0),
        .rst       (rst),
        .push      (rd_inflight),
        .push_data (sram_dout1),
        .pop       (rsp_pop),
        .pop_data  (bus.rd_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.rd_rvalid = !fifo_empty;

endmodule

// File: tb/tb_freepdk45_sram_1w1r_128x52_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freepdk45_sram_1w1r_128x52_ctrl
// Directed bench with a behavioural macro model. Read expectations are pushed
// into a queue when a read is accepted; a monitor pops and compares each
// response the client takes.
// -----------------------------------------------------------------------------
module tb_freepdk45_sram_1w1r_128x52_ctrl;
    import freepdk45_sram_ctrl_pkg::*;

    logic clk0;
    logic rst;
    logic                  init_done;
    logic                  sram_csb0;
    logic [NUM_WMASKS-1:0] sram_wmask0;
    logic [ADDR_WIDTH-1:0] sram_addr0;
    logic [DATA_WIDTH-1:0] sram_din0;
    logic                  sram_csb1;
    logic [ADDR_WIDTH-1:0] sram_addr1;
    logic [DATA_WIDTH-1:0] sram_dout1;

    freepdk45_sram_1w1r_128x52_ctrl_if bus_if ();

    freepdk45_sram_1w1r_128x52_ctrl #(.INIT_ON_RESET(1'b1)) dut (
        .clk0        (clk0),
        .rst         (rst),
        .bus         (bus_if),
        .init_done   (init_done),
        .sram_csb0   (sram_csb0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_csb1   (sram_csb1),
        .sram_addr1  (sram_addr1),
        .sram_dout1  (sram_dout1)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    // Behavioural macro: registered write with 13-bit granules, registered read.
    logic [DATA_WIDTH-1:0] mem [128];
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '1;
        sram_dout1 = '0;
    end
    always @(posedge clk0) begin
        if (!sram_csb0) begin
            for (int m = 0; m < NUM_WMASKS; m++) begin
                if (sram_wmask0[m]) mem[sram_addr0][m*13 +: 13] <= sram_din0[m*13 +: 13];
            end
        end
        if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    end

    int vectors = 0;
    int miscompares = 0;
    logic [DATA_WIDTH-1:0] exp_q [$];

    localparam logic [DATA_WIDTH-1:0] D0   = 52'hF_EDCB_A987_6543;
    localparam logic [DATA_WIDTH-1:0] D1   = 52'h1_2345_6789_ABCD;
    localparam logic [DATA_WIDTH-1:0] D33  = 52'h3_3C3C_5A5A_0F0F;
    localparam logic [DATA_WIDTH-1:0] DM   = 52'hA_BCDE_F012_3456;
    localparam logic [DATA_WIDTH-1:0] DM_X = 52'h0_005E_F000_1456; // granules 0 and 2 of DM

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Presents a read; pushes its expected data if the controller accepts it.
    task automatic rd_try(input string nm, input logic [6:0] a, input logic [51:0] d,
                          input logic exp_rdy);
        bus_if.rd_valid = 1'b1;
        bus_if.rd_addr  = a;
        #1;
        check(nm, bus_if.rd_ready, exp_rdy);
        if (bus_if.rd_ready) exp_q.push_back(d);
    endtask

    // Monitor: compares every response the client takes.
    initial begin
        logic [DATA_WIDTH-1:0] e;
        forever begin
            @(negedge clk0);
            #2;
            if (!rst && bus_if.rd_rvalid && bus_if.rd_rready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rsp_unexpected: got %h expected no response", bus_if.rd_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", bus_if.rd_rdata, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_grant [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [6:0] exp_waddr [4] = '{7'h10, 7'h20, 7'h10, 7'h20};
        int n;

        rst = 1'b1;
        bus_if.wr0_valid = 1'b1; bus_if.wr0_addr = 7'h05; bus_if.wr0_data = D0; bus_if.wr0_wmask = 4'hF;
        bus_if.wr1_valid = 1'b1; bus_if.wr1_addr = 7'h06; bus_if.wr1_data = D1; bus_if.wr1_wmask = 4'hF;
        bus_if.rd_valid  = 1'b1; bus_if.rd_addr  = 7'h07;
        bus_if.rd_rready = 1'b1;

        // Reset state, with every request valid to prove readies are held low.
        repeat (3) @(negedge clk0);
        #1;
        check("rst_wr0_ready", bus_if.wr0_ready, 0);
        check("rst_wr1_ready", bus_if.wr1_ready, 0);
        check("rst_rd_ready",  bus_if.rd_ready,  0);
        check("rst_rvalid",    bus_if.rd_rvalid, 0);
        check("rst_rdata",     bus_if.rd_rdata,  0);
        check("rst_init_done", init_done, 0);
        check("rst_csb0",      sram_csb0, 1);
        check("rst_csb1",      sram_csb1, 1);
        check("rst_addr0",     sram_addr0, 0);
        check("rst_din0",      sram_din0, 0);
        check("rst_wmask0",    sram_wmask0, 0);
        check("rst_addr1",     sram_addr1, 0);

        // Zero-fill sweep: 128 cycles, one address per cycle, readies low.
        @(negedge clk0);
        rst = 1'b0;
        for (int i = 0; i < 128; i++) begin
            #1;
            check("init_addr0", sram_addr0, i);
            check("init_csb0",  sram_csb0, 0);
            check("init_din0",  sram_din0, 0);
            check("init_wmask", sram_wmask0, 4'hF);
            check("init_readies", {bus_if.wr0_ready, bus_if.wr1_ready, bus_if.rd_ready}, 0);
            check("init_done_low", init_done, 0);
            if (i == 127) begin
                bus_if.wr0_valid = 1'b0;
                bus_if.wr1_valid = 1'b0;
                bus_if.rd_valid  = 1'b0;
            end
            @(negedge clk0);
        end
        #1;
        check("init_done_129", init_done, 1);
        check("run_idle_csb0", sram_csb0, 1);

        // Read 0x7F after sweep: zero, valid exactly two cycles after accept.
        @(negedge clk0);
        rd_try("rd7f_ready", 7'h7F, 52'h0, 1);
        @(negedge clk0);
        bus_if.rd_valid = 1'b0;
        #2 check("rd_lat_n1", bus_if.rd_rvalid, 0);
        @(negedge clk0);
        #2 check("rd_lat_n2", bus_if.rd_rvalid, 1);

        // Masked write via wr1 (granules 0 and 2), then read back.
        @(negedge clk0);
        bus_if.wr1_valid = 1'b1; bus_if.wr1_addr = 7'h10; bus_if.wr1_data = DM; bus_if.wr1_wmask = 4'b0101;
        #1;
        check("mask_wr1_ready", bus_if.wr1_ready, 1);
        check("mask_wmask0", sram_wmask0, 4'b0101);
        @(negedge clk0);
        bus_if.wr1_valid = 1'b0;
        rd_try("mask_rd_ready", 7'h10, DM_X, 1);
        @(negedge clk0);
        bus_if.rd_valid = 1'b0;

        // Round-robin: both valid for 4 cycles.
        @(negedge clk0);
        bus_if.wr0_valid = 1'b1; bus_if.wr0_addr = 7'h10; bus_if.wr0_data = D0; bus_if.wr0_wmask = 4'hF;
        bus_if.wr1_valid = 1'b1; bus_if.wr1_addr = 7'h20; bus_if.wr1_data = D1; bus_if.wr1_wmask = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("arb_grant", {bus_if.wr1_ready, bus_if.wr0_ready}, exp_grant[k]);
            check("arb_addr0", sram_addr0, exp_waddr[k]);
            @(negedge clk0);
        end
        bus_if.wr0_valid = 1'b0;
        bus_if.wr1_valid = 1'b0;

        // Back-to-back reads with rd_rready high: one accept per cycle.
        rd_try("tput_rd0", 7'h10, D0, 1);
        @(negedge clk0);
        rd_try("tput_rd1", 7'h20, D1, 1);
        @(negedge clk0);
        rd_try("tput_rd2", 7'h7F, 52'h0, 1);
        @(negedge clk0);
        bus_if.rd_valid = 1'b0;

        // Same-cycle write and read to 0x33: write wins, read follows.
        @(negedge clk0);
        bus_if.wr0_valid = 1'b1; bus_if.wr0_addr = 7'h33; bus_if.wr0_data = D33; bus_if.wr0_wmask = 4'hF;
        rd_try("coll_rd_blocked", 7'h33, D33, 0);
        check("coll_wr0_ready", bus_if.wr0_ready, 1);
        @(negedge clk0);
        bus_if.wr0_valid = 1'b0;
        rd_try("coll_rd_next", 7'h33, D33, 1);
        @(negedge clk0);
        bus_if.rd_valid = 1'b0;

        // Back-pressure: third read waits for credit, responses held stable.
        repeat (4) @(negedge clk0);
        bus_if.rd_rready = 1'b0;
        rd_try("bp_rd0", 7'h10, D0, 1);
        @(negedge clk0);
        rd_try("bp_rd1", 7'h20, D1, 1);
        @(negedge clk0);
        rd_try("bp_rd2_stall", 7'h33, D33, 0);
        @(negedge clk0);
        rd_try("bp_rd2_stall2", 7'h33, D33, 0);
        check("bp_hold_valid", bus_if.rd_rvalid, 1);
        check("bp_hold_data",  bus_if.rd_rdata, D0);
        @(negedge clk0);
        rd_try("bp_rd2_stall3", 7'h33, D33, 0);
        check("bp_hold_data2", bus_if.rd_rdata, D0);
        @(negedge clk0);
        bus_if.rd_rready = 1'b1;
        rd_try("bp_rd2_release", 7'h33, D33, 1);
        @(negedge clk0);
        bus_if.rd_valid = 1'b0;

        // Reset with two responses queued.
        repeat (4) @(negedge clk0);
        bus_if.rd_rready = 1'b0;
        rd_try("rst_fill0", 7'h10, D0, 1);
        @(negedge clk0);
        rd_try("rst_fill1", 7'h20, D1, 1);
        @(negedge clk0);
        bus_if.rd_valid = 1'b0;
        @(negedge clk0);
        #1 check("rst_fifo_full_valid", bus_if.rd_rvalid, 1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk0);
        #1;
        check("mid_rst_rvalid", bus_if.rd_rvalid, 0);
        check("mid_rst_init_done", init_done, 0);
        check("mid_rst_csb0", sram_csb0, 1);
        rst = 1'b0;
        #1;
        check("reinit_addr_0", sram_addr0, 0);
        check("reinit_csb0", sram_csb0, 0);
        @(negedge clk0);
        #1 check("reinit_addr_1", sram_addr0, 1);
        @(negedge clk0);
        #1 check("reinit_addr_2", sram_addr0, 2);
        n = 0;
        while (!init_done && n < 200) begin
            @(negedge clk0);
            #1;
            n++;
        end
        check("reinit_done", init_done, 1);
        check("reinit_len", n, 126);
        check("reinit_rvalid", bus_if.rd_rvalid, 0);

        // Priority returns to wr0 after reset (last pre-reset grant was wr0).
        @(negedge clk0);
        bus_if.wr0_valid = 1'b1; bus_if.wr0_addr = 7'h40;
        bus_if.wr1_valid = 1'b1; bus_if.wr1_addr = 7'h41;
        #1 check("rst_prio_wr0", {bus_if.wr1_ready, bus_if.wr0_ready}, 2'b01);
        @(negedge clk0);
        bus_if.wr0_valid = 1'b0;
        bus_if.wr1_valid = 1'b0;
        bus_if.rd_rready = 1'b1;
        repeat (4) @(negedge clk0);
        check("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
